mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
MEM/WB pipeline stage that sits directly upstream of the 32x32 register file write port and drives its WriteRegister, WriteData and RegWrite inputs.
- Captures MEM-stage results and performs big-endian load extraction (byte/half, signed/unsigned).
- Selects the writeback source (ALU result, load data or link address) and suppresses writes to $zero.
- Tracks retired instructions.
- Its registered outputs double as the WB forwarding source for the hazard/forwarding logic.

Parameters:
DATA_WIDTH, 32, datapath width; all data ports use it.
REG_ADDR_WIDTH, 5, register address width.
LINK_REG, 31, destination forced for link writebacks (jal/jalr).

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-low reset.
Stall  input  1  hold the current WB contents.
Flush  input  1  insert a bubble into WB.
MemValid  input  1  MEM stage holds a real instruction.
MemRegWrite  input  1  instruction writes a register.
MemToReg  input  2  source select: 00 ALU, 01 load, 10 link, 11 reserved (treated as ALU).
MemLoadType  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; other codes treated as lw.
MemWriteReg  input  5  destination register.
MemAluResult  input  32  ALU result; bits [1:0] are the load byte offset.
MemReadData  input  32  raw word from data memory.
MemPCPlus4  input  32  link value.
WriteRegister  output  5  to register file.
WriteData  output  32  to register file.
RegWrite  output  1  to register file.
WbValid  output  1  WB holds a real instruction.
LoadMisaligned  output  1  registered flag: the WB instruction was a misaligned load.
InstrRetired  output  32  retired-instruction counter.

Behaviour:
- Reset (asynchronous, while Reset=0):
  - WbValid=0, RegWrite=0, WriteRegister=0, WriteData=0, LoadMisaligned=0, InstrRetired=0.
  - Outputs change immediately, without waiting for a clock edge.
  - Deasserting Reset mid-stream resumes normal capture on the next rising edge; any in-flight instruction is lost.
- Latency:
  - Exactly one cycle from MEM inputs to WB outputs.
  - All outputs are registered; nothing passes combinationally from inputs to outputs.
- Per rising edge, in priority order:
  1. Flush=1: WbValid<=0, RegWrite<=0, LoadMisaligned<=0; WriteRegister and WriteData hold. Flush beats Stall.
  2. Stall=1: all WB registers hold, counter holds.
  3. Otherwise: capture the MEM inputs as below.
- Load extraction (big-endian), offset o = MemAluResult[1:0]:
  - lb/lbu: byte o=0 -> [31:24], o=1 -> [23:16], o=2 -> [15:8], o=3 -> [7:0]; sign- or zero-extend to 32.
  - lh/lhu: o[1]=0 -> [31:16], o[1]=1 -> [15:0]; o[0] is ignored; sign- or zero-extend.
  - lw: the word is passed unmodified.
  - Misaligned = load source AND ((lh/lhu AND o[0]) OR (lw AND o!=0)). Data is still written.
- Writeback select:
  - WriteData = ALU result, extracted load data, or MemPCPlus4, per MemToReg.
  - WriteRegister = LINK_REG when MemToReg=10, otherwise MemWriteReg.
- RegWrite <= MemValid AND MemRegWrite AND (selected destination != 0).
  - A write to $zero is dropped here, so the register file never sees RegWrite=1 with WriteRegister=0.
- WbValid <= MemValid.
- InstrRetired:
  - Increments by 1 on every capture edge with MemValid=1.
  - Does not count on stall or flush edges, or when MemValid=0.
  - Wraps 0xFFFFFFFF -> 0 without a flag.
- Stall held for N cycles: outputs stay constant, so the register file rewrites the same value each cycle. This is harmless and required.
- Flushing a previously valid instruction removes only the write enable; WriteData holds its last value.

Test Plan:
- Reset mid-operation: run valid ALU writes to $8, pull Reset low between edges -> outputs go to 0 before the next edge. Release Reset -> the next capture is written normally.
- lb, MemAluResult=0x00000001, MemReadData=0x12F45678, dest $9 -> next cycle WriteData=0xFFFFFFF4, RegWrite=1, WriteRegister=9. Repeat with lbu -> 0x000000F4.
- lhu, offset 2, data 0x1234ABCD -> 0x0000ABCD. lh, offset 3 -> 0xFFFFABCD, LoadMisaligned=1. lw, offset 0 -> 0x1234ABCD, LoadMisaligned=0.
- ALU write with MemWriteReg=0, MemValid=1 -> RegWrite=0, WbValid=1, InstrRetired increments. Link: MemToReg=10, MemPCPlus4=0x00000040 -> WriteRegister=31, WriteData=0x00000040.
- Stall=1 and Flush=1 on the same edge with a valid instruction in WB -> WbValid=0, RegWrite=0, counter unchanged. Stall alone for 3 cycles -> outputs frozen, counter frozen.
- Force InstrRetired to 0xFFFFFFFF, then capture one valid instruction -> InstrRetired=0x00000000.

Source files
------------

// File: rtl/mem_wb_writeback_if.sv
// MEM -> WB pipeline bus: MEM-stage results in, register-file write port and
// WB forwarding/status signals out.
interface mem_wb_writeback_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      Stall;
  logic                      Flush;
  logic                      MemValid;
  logic                      MemRegWrite;
  logic [1:0]                MemToReg;
  logic [2:0]                MemLoadType;
  logic [REG_ADDR_WIDTH-1:0] MemWriteReg;
  logic [DATA_WIDTH-1:0]     MemAluResult;
  logic [DATA_WIDTH-1:0]     MemReadData;
  logic [DATA_WIDTH-1:0]     MemPCPlus4;

  logic [REG_ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0]     WriteData;
  logic                      RegWrite;
  logic                      WbValid;
  logic                      LoadMisaligned;
  logic [31:0]               InstrRetired;

  // MEM stage / pipeline control side
  modport master (
    output Stall, Flush, MemValid, MemRegWrite, MemToReg, MemLoadType,
           MemWriteReg, MemAluResult, MemReadData, MemPCPlus4,
    input  WriteRegister, WriteData, RegWrite, WbValid, LoadMisaligned,
           InstrRetired
  );

  // WB stage
  modport slave (
    input  Stall, Flush, MemValid, MemRegWrite, MemToReg, MemLoadType,
           MemWriteReg, MemAluResult, MemReadData, MemPCPlus4,
    output WriteRegister, WriteData, RegWrite, WbValid, LoadMisaligned,
           InstrRetired
  );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register: big-endian load extraction, writeback source select,
// $zero write suppression and retired-instruction counting. All outputs registered.
module mem_wb_writeback #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_REG       = 31
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_wb_writeback_if.slave wb
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  localparam logic [REG_ADDR_WIDTH-1:0] LINK_ADDR = REG_ADDR_WIDTH'(LINK_REG);

  logic [REG_ADDR_WIDTH-1:0] write_register_q, write_register_d;
  logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;
  logic                      reg_write_q, reg_write_d;
  logic                      wb_valid_q;
  logic                      load_misaligned_q, load_misaligned_d;
  logic [31:0]               instr_retired_q;

  logic [1:0]            offset;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic                  is_byte, is_half, is_signed;
  logic [DATA_WIDTH-1:0] load_data;

  assign offset    = wb.MemAluResult[1:0];
  assign is_byte   = (wb.MemLoadType == LT_LB) || (wb.MemLoadType == LT_LBU);
  assign is_half   = (wb.MemLoadType == LT_LH) || (wb.MemLoadType == LT_LHU);
  assign is_signed = (wb.MemLoadType == LT_LB) || (wb.MemLoadType == LT_LH);

  // Big-endian lanes: offset 0 is the most significant byte of the word.
  always_comb begin
    load_byte = '0;
    case (offset)
      2'd0:    load_byte = wb.MemReadData[DATA_WIDTH-1  -: 8];
      2'd1:    load_byte = wb.MemReadData[DATA_WIDTH-9  -: 8];
      2'd2:    load_byte = wb.MemReadData[DATA_WIDTH-17 -: 8];
      default: load_byte = wb.MemReadData[DATA_WIDTH-25 -: 8];
    endcase
  end

  assign load_half = offset[1] ? wb.MemReadData[DATA_WIDTH-17 -: 16]
                               : wb.MemReadData[DATA_WIDTH-1  -: 16];

  always_comb begin
    load_data = wb.MemReadData;
    if (is_byte) begin
      load_data = {{(DATA_WIDTH-8){is_signed & load_byte[7]}}, load_byte};
    end else if (is_half) begin
      load_data = {{(DATA_WIDTH-16){is_signed & load_half[15]}}, load_half};
    end
  end

  always_comb begin
    write_data_d     = wb.MemAluResult;
    write_register_d = wb.MemWriteReg;
    case (wb.MemToReg)
      SRC_LOAD: write_data_d = load_data;
      SRC_LINK: begin
        write_data_d     = wb.MemPCPlus4;
        write_register_d = LINK_ADDR;
      end
      default:  write_data_d = wb.MemAluResult;
    endcase
  end

  // Dropping $zero writes here keeps the register file free of a zero-guard.
  assign reg_write_d = wb.MemValid && wb.MemRegWrite && (write_register_d != '0);

  // Byte loads can never be misaligned; unknown load codes behave as lw.
  assign load_misaligned_d = (wb.MemToReg == SRC_LOAD) &&
                             ((is_half && offset[0]) ||
                              (!is_byte && !is_half && (offset != 2'd0)));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      write_register_q  <= '0;
      write_data_q      <= '0;
      reg_write_q       <= 1'b0;
      wb_valid_q        <= 1'b0;
      load_misaligned_q <= 1'b0;
      instr_retired_q   <= '0;
    end else if (wb.Flush) begin
      reg_write_q       <= 1'b0;
      wb_valid_q        <= 1'b0;
      load_misaligned_q <= 1'b0;
    end else if (!wb.Stall) begin
      write_register_q  <= write_register_d;
      write_data_q      <= write_data_d;
      reg_write_q       <= reg_write_d;
      wb_valid_q        <= wb.MemValid;
      load_misaligned_q <= load_misaligned_d;
      if (wb.MemValid) begin
        instr_retired_q <= instr_retired_q + 32'd1;
      end
    end
  end

  assign wb.WriteRegister  = write_register_q;
  assign wb.WriteData      = write_data_q;
  assign wb.RegWrite       = reg_write_q;
  assign wb.WbValid        = wb_valid_q;
  assign wb.LoadMisaligned = load_misaligned_q;
  assign wb.InstrRetired   = instr_retired_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: vector table applied through a scoreboard queue,
// followed by stall, flush, mid-stream reset and counter-wrap sequences.
module tb_mem_wb_writeback;

  typedef struct {
    string       nm;
    logic        valid;
    logic        rw;
    logic [1:0]  m2r;
    logic [2:0]  lt;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_rw;
    logic        e_v;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] model_cnt = 32'd0;
  vec_t        exp_q[$];
  vec_t        last;
  vec_t        vecs[16];

  mem_wb_writeback_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  mem_wb_writeback #(
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5),
    .LINK_REG(31)
  ) dut (
    .Clk  (clk),
    .Reset(rst_n),
    .wb   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(string nm, logic valid, logic rw, logic [1:0] m2r,
                              logic [2:0] lt, logic [4:0] wr, logic [31:0] alu,
                              logic [31:0] rd, logic [31:0] pc, logic [4:0] e_wr,
                              logic [31:0] e_wd, logic e_rw, logic e_mis);
    vec_t v;
    v.nm = nm; v.valid = valid; v.rw = rw; v.m2r = m2r; v.lt = lt; v.wr = wr;
    v.alu = alu; v.rd = rd; v.pc = pc; v.e_wr = e_wr; v.e_wd = e_wd;
    v.e_rw = e_rw; v.e_v = valid; v.e_mis = e_mis; v.e_cnt = 32'd0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic drive(input vec_t v);
    vec_t e;
    bus.Stall        = 1'b0;
    bus.Flush        = 1'b0;
    bus.MemValid     = v.valid;
    bus.MemRegWrite  = v.rw;
    bus.MemToReg     = v.m2r;
    bus.MemLoadType  = v.lt;
    bus.MemWriteReg  = v.wr;
    bus.MemAluResult = v.alu;
    bus.MemReadData  = v.rd;
    bus.MemPCPlus4   = v.pc;
    if (v.valid) model_cnt = model_cnt + 32'd1;
    e       = v;
    e.e_cnt = model_cnt;
    exp_q.push_back(e);
  endtask

  task automatic cmp_all(input string nm, input vec_t e);
    chk({nm, ".WriteRegister"},  {27'd0, bus.WriteRegister}, {27'd0, e.e_wr});
    chk({nm, ".WriteData"},      bus.WriteData, e.e_wd);
    chk({nm, ".RegWrite"},       {31'd0, bus.RegWrite}, {31'd0, e.e_rw});
    chk({nm, ".WbValid"},        {31'd0, bus.WbValid}, {31'd0, e.e_v});
    chk({nm, ".LoadMisaligned"}, {31'd0, bus.LoadMisaligned}, {31'd0, e.e_mis});
    chk({nm, ".InstrRetired"},   bus.InstrRetired, e.e_cnt);
  endtask

  task automatic check_out();
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard: got output with empty queue, expected a pending entry");
    end else begin
      last = exp_q.pop_front();
      cmp_all(last.nm, last);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_zero(input string nm);
    vec_t z;
    z = mk(nm, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0,
           5'd0, 32'd0, 1'b0, 1'b0);
    cmp_all(nm, z);
  endtask

  initial begin
    vecs[0]  = mk("alu_r8",     1, 1, 2'b00, 3'b000, 5'd8,  32'h1111_1111, 32'h0, 32'h0,
                  5'd8,  32'h1111_1111, 1, 0);
    vecs[1]  = mk("lb_o1",      1, 1, 2'b01, 3'b001, 5'd9,  32'h0000_0001, 32'h12F4_5678, 32'h0,
                  5'd9,  32'hFFFF_FFF4, 1, 0);
    vecs[2]  = mk("lbu_o1",     1, 1, 2'b01, 3'b010, 5'd9,  32'h0000_0001, 32'h12F4_5678, 32'h0,
                  5'd9,  32'h0000_00F4, 1, 0);
    vecs[3]  = mk("lhu_o2",     1, 1, 2'b01, 3'b100, 5'd10, 32'h0000_0002, 32'h1234_ABCD, 32'h0,
                  5'd10, 32'h0000_ABCD, 1, 0);
    vecs[4]  = mk("lh_o3",      1, 1, 2'b01, 3'b011, 5'd10, 32'h0000_0003, 32'h1234_ABCD, 32'h0,
                  5'd10, 32'hFFFF_ABCD, 1, 1);
    vecs[5]  = mk("lw_o0",      1, 1, 2'b01, 3'b000, 5'd11, 32'h0000_0100, 32'h1234_ABCD, 32'h0,
                  5'd11, 32'h1234_ABCD, 1, 0);
    vecs[6]  = mk("lw_o2",      1, 1, 2'b01, 3'b000, 5'd11, 32'h0000_0102, 32'h1234_ABCD, 32'h0,
                  5'd11, 32'h1234_ABCD, 1, 1);
    vecs[7]  = mk("lb_o0",      1, 1, 2'b01, 3'b001, 5'd12, 32'h0000_0000, 32'h12F4_5678, 32'h0,
                  5'd12, 32'h0000_0012, 1, 0);
    vecs[8]  = mk("lb_o3",      1, 1, 2'b01, 3'b001, 5'd12, 32'h0000_0003, 32'h12F4_5680, 32'h0,
                  5'd12, 32'hFFFF_FF80, 1, 0);
    vecs[9]  = mk("lbu_o2",     1, 1, 2'b01, 3'b010, 5'd13, 32'h0000_0002, 32'h12F4_5678, 32'h0,
                  5'd13, 32'h0000_0056, 1, 0);
    vecs[10] = mk("alu_r0",     1, 1, 2'b00, 3'b000, 5'd0,  32'hDEAD_BEEF, 32'h0, 32'h0,
                  5'd0,  32'hDEAD_BEEF, 0, 0);
    vecs[11] = mk("link",       1, 1, 2'b10, 3'b000, 5'd5,  32'hCAFE_0000, 32'h0, 32'h0000_0040,
                  5'd31, 32'h0000_0040, 1, 0);
    vecs[12] = mk("src_rsvd",   1, 1, 2'b11, 3'b000, 5'd6,  32'h0BAD_F00D, 32'h7777_7777, 32'h44,
                  5'd6,  32'h0BAD_F00D, 1, 0);
    vecs[13] = mk("invalid",    0, 1, 2'b00, 3'b000, 5'd7,  32'h0000_00AA, 32'h0, 32'h0,
                  5'd7,  32'h0000_00AA, 0, 0);
    vecs[14] = mk("no_regwr",   1, 0, 2'b00, 3'b000, 5'd14, 32'h0000_00BB, 32'h0, 32'h0,
                  5'd14, 32'h0000_00BB, 0, 0);
    vecs[15] = mk("lt_unknown", 1, 1, 2'b01, 3'b111, 5'd15, 32'h0000_0001, 32'hA1B2_C3D4, 32'h0,
                  5'd15, 32'hA1B2_C3D4, 1, 1);

    bus.Stall = 0; bus.Flush = 0; bus.MemValid = 0; bus.MemRegWrite = 0;
    bus.MemToReg = 0; bus.MemLoadType = 0; bus.MemWriteReg = 0;
    bus.MemAluResult = 0; bus.MemReadData = 0; bus.MemPCPlus4 = 0;

    #1 rst_n = 1'b0;
    #2 check_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
    end

    // Stall for three edges with different MEM inputs: everything frozen.
    apply(vecs[0]);
    @(negedge clk);
    bus.MemValid = 1'b1; bus.MemRegWrite = 1'b1; bus.MemWriteReg = 5'd20;
    bus.MemAluResult = 32'h5A5A_5A5A; bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      cmp_all($sformatf("stall%0d", i), last);
    end

    // Stall and Flush together: bubble wins, data/address hold, counter holds.
    @(negedge clk);
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    last.e_rw  = 1'b0;
    last.e_v   = 1'b0;
    last.e_mis = 1'b0;
    cmp_all("stall_flush", last);

    // Mid-stream asynchronous reset between edges.
    apply(vecs[0]);
    apply(vecs[0]);
    @(negedge clk);
    drive(vecs[0]);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    model_cnt = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk("after_reset", 1, 1, 2'b00, 3'b000, 5'd8, 32'h0000_0055, 32'h0, 32'h0,
             5'd8, 32'h0000_0055, 1, 0));
    @(posedge clk);
    #1;
    check_out();

    // Counter wrap.
    @(negedge clk);
    force dut.instr_retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_retired_q;
    model_cnt = 32'hFFFF_FFFF;
    drive(mk("wrap", 1, 1, 2'b00, 3'b000, 5'd3, 32'h0000_0033, 32'h0, 32'h0,
             5'd3, 32'h0000_0033, 1, 0));
    @(posedge clk);
    #1;
    check_out();

    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
